csr_unit: RTL and testbench

CSR_UNIT -- requirements
Module: csr_unit

---
 rtl/csr_unit.sv | 158 +++++++++++++++
 tb/tb_csr_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/csr_unit.sv
// CSR/trap sequencer: runs one CSR op, ECALL/EBREAK or MRET per request
// through a three-state IDLE -> EXEC -> RESP handshake.
module csr_unit #(
  parameter bit TRAP_ON_RO_WRITE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_kind,
  input  logic [2:0]  req_funct3,
  input  logic [11:0] req_csr,
  input  logic [31:0] req_rs1_val,
  input  logic [4:0]  req_zimm,
  input  logic        req_rd_nz,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_rd_we,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [11:0] csr_addr,
  input  logic [31:0] csr_rdata,
  output logic        csr_write,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        trap_taken,
  output logic [31:0] trap_cause,
  output logic [31:0] trap_pc,
  output logic        mret_taken
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  localparam logic [1:0] KindCsr    = 2'd0;
  localparam logic [1:0] KindEcall  = 2'd1;
  localparam logic [1:0] KindEbreak = 2'd2;
  localparam logic [1:0] KindMret   = 2'd3;

  state_e      state_q;
  logic [1:0]  kind_q;
  logic [2:0]  funct3_q;
  logic [11:0] csr_q;
  logic [31:0] rs1_q;
  logic [4:0]  zimm_q;
  logic        rd_nz_q;
  logic [31:0] pc_q;
  logic [31:0] data_q;   // old CSR value, or redirect target when redir_q
  logic        redir_q;

  logic [31:0] src, new_val, cause;
  logic        intent, illegal, is_trap, is_mret, csr_ok;

  always_comb begin
    src = funct3_q[2] ? {27'b0, zimm_q} : rs1_q;
    case (funct3_q[1:0])
      2'b10:   new_val = csr_rdata | src;
      2'b11:   new_val = csr_rdata & ~src;
      default: new_val = src;
    endcase
    // Set/clear with a zero source (x0 or zimm=0) never writes.
    intent  = (funct3_q[1:0] == 2'b01) || (zimm_q != 5'd0);
    illegal = (kind_q == KindCsr) &&
              ((funct3_q[1:0] == 2'b00) ||
               (TRAP_ON_RO_WRITE && intent && (csr_q[11:10] == 2'b11)));
    is_trap = illegal || (kind_q == KindEcall) || (kind_q == KindEbreak);
    is_mret = (kind_q == KindMret);
    csr_ok  = (kind_q == KindCsr) && !illegal;
    if (illegal)                  cause = 32'd2;
    else if (kind_q == KindEcall) cause = 32'd11;
    else if (kind_q == KindEbreak) cause = 32'd3;
    else                          cause = 32'd0;
  end

  always_comb begin
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_rdata     = 32'd0;
    resp_rd_we     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    csr_addr       = 12'd0;
    csr_write      = 1'b0;
    csr_waddr      = 12'd0;
    csr_wdata      = 32'd0;
    trap_taken     = 1'b0;
    trap_cause     = 32'd0;
    trap_pc        = 32'd0;
    mret_taken     = 1'b0;
    unique case (state_q)
      StIdle: req_ready = 1'b1;
      StExec: begin
        csr_addr = is_trap ? 12'h305 : (is_mret ? 12'h341 : csr_q);
        if (csr_ok) begin
          csr_write = intent;
          csr_waddr = csr_q;
          csr_wdata = new_val;
        end
        trap_taken = is_trap;
        if (is_trap) begin
          trap_cause = cause;
          trap_pc    = pc_q;
        end
        mret_taken = is_mret;
      end
      StResp: begin
        resp_valid     = 1'b1;
        resp_rdata     = redir_q ? 32'd0 : data_q;
        resp_rd_we     = !redir_q && rd_nz_q;
        redirect_valid = redir_q;
        redirect_pc    = redir_q ? data_q : 32'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      kind_q   <= 2'd0;
      funct3_q <= 3'd0;
      csr_q    <= 12'd0;
      rs1_q    <= 32'd0;
      zimm_q   <= 5'd0;
      rd_nz_q  <= 1'b0;
      pc_q     <= 32'd0;
      data_q   <= 32'd0;
      redir_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            kind_q   <= req_kind;
            funct3_q <= req_funct3;
            csr_q    <= req_csr;
            rs1_q    <= req_rs1_val;
            zimm_q   <= req_zimm;
            rd_nz_q  <= req_rd_nz;
            pc_q     <= req_pc;
            state_q  <= StExec;
          end
        end
        StExec: begin
          // mtvec mode bits are dropped: always direct mode.
          data_q  <= is_trap ? {csr_rdata[31:2], 2'b00} : csr_rdata;
          redir_q <= is_trap || is_mret;
          state_q <= StResp;
        end
        StResp: begin
          if (resp_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: a small CSR file answers csr_addr, each
// operation's pulses and response are compared against hand-computed values.
module tb_csr_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_kind;
  logic [2:0]  req_funct3;
  logic [11:0] req_csr;
  logic [31:0] req_rs1_val;
  logic [4:0]  req_zimm;
  logic        req_rd_nz;
  logic [31:0] req_pc;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_rd_we;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata;
  logic        csr_write;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        trap_taken;
  logic [31:0] trap_cause, trap_pc;
  logic        mret_taken;

  logic [31:0] mscratch, mstatus, mtvec, mepc;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  csr_unit #(.TRAP_ON_RO_WRITE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_funct3(req_funct3), .req_csr(req_csr), .req_rs1_val(req_rs1_val),
    .req_zimm(req_zimm), .req_rd_nz(req_rd_nz), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_rd_we(resp_rd_we), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .csr_addr(csr_addr), .csr_rdata(csr_rdata),
    .csr_write(csr_write), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .trap_taken(trap_taken), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .mret_taken(mret_taken)
  );

  always_comb begin
    csr_rdata = 32'd0;
    case (csr_addr)
      12'h340: csr_rdata = mscratch;
      12'h300: csr_rdata = mstatus;
      12'h305: csr_rdata = mtvec;
      12'h341: csr_rdata = mepc;
      12'hC00: csr_rdata = 32'hC0C0_0001;
      default: csr_rdata = 32'd0;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents a request at a falling edge; returns at the falling edge inside EXEC.
  task automatic issue(input logic [1:0] kind, input logic [2:0] f3, input logic [11:0] csr,
                       input logic [31:0] rs1, input logic [4:0] zimm, input logic rdnz,
                       input logic [31:0] pc);
    req_kind = kind; req_funct3 = f3; req_csr = csr; req_rs1_val = rs1;
    req_zimm = zimm; req_rd_nz = rdnz; req_pc = pc; req_valid = 1'b1;
    check_eq("accept_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic release_resp();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check_eq("back_idle", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_kind = 2'd0; req_funct3 = 3'd0; req_csr = 12'd0; req_rs1_val = 32'd0;
    req_zimm = 5'd0; req_rd_nz = 1'b0; req_pc = 32'd0;
    mscratch = 32'h1234_5678; mstatus = 32'h0000_1800;
    mtvec = 32'h8000_0103; mepc = 32'h0000_0104;
    repeat (2) @(negedge clk);
    check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_eq("rst_csr_addr", {20'd0, csr_addr}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // CSRRW 0x340
    issue(2'd0, 3'd1, 12'h340, 32'hDEAD_BEEF, 5'd1, 1'b1, 32'h0000_0040);
    check_eq("rw_csr_addr", {20'd0, csr_addr}, 32'h340);
    check_eq("rw_write", {31'd0, csr_write}, 32'd1);
    check_eq("rw_waddr", {20'd0, csr_waddr}, 32'h340);
    check_eq("rw_wdata", csr_wdata, 32'hDEAD_BEEF);
    check_eq("rw_no_trap", {31'd0, trap_taken}, 32'd0);
    @(negedge clk);
    check_eq("rw_resp_valid", {31'd0, resp_valid}, 32'd1);
    check_eq("rw_rdata", resp_rdata, 32'h1234_5678);
    check_eq("rw_rd_we", {31'd0, resp_rd_we}, 32'd1);
    check_eq("rw_no_redirect", {31'd0, redirect_valid}, 32'd0);
    check_eq("rw_resp_write", {31'd0, csr_write}, 32'd0);
    check_eq("rw_resp_waddr", {20'd0, csr_waddr}, 32'd0);
    release_resp();

    // CSRRS with rs1=x0 on mstatus: read only
    issue(2'd0, 3'd2, 12'h300, 32'hFFFF_FFFF, 5'd0, 1'b1, 32'h0000_0044);
    check_eq("rs0_write", {31'd0, csr_write}, 32'd0);
    check_eq("rs0_trap", {31'd0, trap_taken}, 32'd0);
    @(negedge clk);
    check_eq("rs0_rdata", resp_rdata, 32'h0000_1800);
    release_resp();

    // CSRRCI zimm=8 with old=0x88
    mscratch = 32'h0000_0088;
    issue(2'd0, 3'd7, 12'h340, 32'hFFFF_FFFF, 5'd8, 1'b0, 32'h0000_0048);
    check_eq("rci_write", {31'd0, csr_write}, 32'd1);
    check_eq("rci_wdata", csr_wdata, 32'h0000_0080);
    @(negedge clk);
    check_eq("rci_rd_we", {31'd0, resp_rd_we}, 32'd0);
    release_resp();

    // CSRRS x0 on read-only CSR is a legal read
    issue(2'd0, 3'd2, 12'hC00, 32'd5, 5'd0, 1'b1, 32'h0000_004C);
    check_eq("ro_read_trap", {31'd0, trap_taken}, 32'd0);
    @(negedge clk);
    check_eq("ro_read_rdata", resp_rdata, 32'hC0C0_0001);
    release_resp();

    // CSRRW to read-only CSR traps
    issue(2'd0, 3'd1, 12'hC00, 32'd1, 5'd3, 1'b1, 32'h0000_0200);
    check_eq("ro_wr_write", {31'd0, csr_write}, 32'd0);
    check_eq("ro_wr_trap", {31'd0, trap_taken}, 32'd1);
    check_eq("ro_wr_cause", trap_cause, 32'd2);
    check_eq("ro_wr_pc", trap_pc, 32'h0000_0200);
    check_eq("ro_wr_addr", {20'd0, csr_addr}, 32'h305);
    @(negedge clk);
    check_eq("ro_wr_redir", {31'd0, redirect_valid}, 32'd1);
    check_eq("ro_wr_target", redirect_pc, 32'h8000_0100);
    check_eq("ro_wr_rd_we", {31'd0, resp_rd_we}, 32'd0);
    check_eq("ro_wr_cause_off", trap_cause, 32'd0);
    release_resp();

    // Reserved funct3=4
    issue(2'd0, 3'd4, 12'h340, 32'd1, 5'd1, 1'b1, 32'h0000_0204);
    check_eq("f3_4_cause", trap_cause, 32'd2);
    @(negedge clk);
    release_resp();

    // ECALL / EBREAK
    issue(2'd1, 3'd0, 12'h000, 32'd0, 5'd0, 1'b0, 32'h0000_0100);
    check_eq("ecall_trap", {31'd0, trap_taken}, 32'd1);
    check_eq("ecall_cause", trap_cause, 32'd11);
    check_eq("ecall_pc", trap_pc, 32'h0000_0100);
    check_eq("ecall_mret", {31'd0, mret_taken}, 32'd0);
    @(negedge clk);
    release_resp();
    issue(2'd2, 3'd0, 12'h000, 32'd0, 5'd0, 1'b0, 32'h0000_0108);
    check_eq("ebreak_cause", trap_cause, 32'd3);
    @(negedge clk);
    release_resp();

    // MRET
    issue(2'd3, 3'd0, 12'h000, 32'd0, 5'd0, 1'b1, 32'h0000_0300);
    check_eq("mret_pulse", {31'd0, mret_taken}, 32'd1);
    check_eq("mret_addr", {20'd0, csr_addr}, 32'h341);
    check_eq("mret_no_trap", {31'd0, trap_taken}, 32'd0);
    @(negedge clk);
    check_eq("mret_redir", {31'd0, redirect_valid}, 32'd1);
    check_eq("mret_target", redirect_pc, 32'h0000_0104);
    check_eq("mret_rd_we", {31'd0, resp_rd_we}, 32'd0);
    release_resp();

    // CSRRSI with back-pressure on the response
    mscratch = 32'h0000_0010;
    issue(2'd0, 3'd6, 12'h340, 32'd0, 5'd3, 1'b1, 32'h0000_0400);
    check_eq("rsi_wdata", csr_wdata, 32'h0000_0013);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("stall_valid", {31'd0, resp_valid}, 32'd1);
      check_eq("stall_rdata", resp_rdata, 32'h0000_0010);
      check_eq("stall_ready", {31'd0, req_ready}, 32'd0);
      check_eq("stall_write", {31'd0, csr_write}, 32'd0);
    end
    release_resp();

    // Reset while in EXEC drops the op
    issue(2'd1, 3'd0, 12'h000, 32'd0, 5'd0, 1'b0, 32'h0000_0500);
    rst = 1'b1;
    #1;
    check_eq("rst_exec_trap", {31'd0, trap_taken}, 32'd0);
    check_eq("rst_exec_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_exec_cause", trap_cause, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_exec_resp", {31'd0, resp_valid}, 32'd0);
    check_eq("rst_exec_pulse", {31'd0, trap_taken}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
